lift_controller: RTL and testbench
==================================

// Module: lift_controller
// PURPOSE
//  Single-car elevator controller for up to 8 floors (0..7). Latches hall calls
//  (pass_f + butt_up_down), drives the car to the calling floor, opens the door,
//  accepts the in-car destination (butt_el), then carries the passenger there.
//  Reports the current car floor and a busy flag. Top-level controller; no bus.
// PARAMETERS
//  NUM_FLOORS   8  number of served floors; floors 0..NUM_FLOORS-1, max 8
//  MOVE_CYCLES  4  clock cycles to travel one floor (>=1)
//  DOOR_CYCLES  3  clock cycles the door stays open per stop (>=1)
// PORTS
//  clk           in   1  system clock, rising edge
//  rst_n         in   1  reset, asynchronous, active-high (despite name)
//  butt_el       in   3  in-car destination floor, sampled at end of pickup door
//  butt_up_down  in   1  hall-call button; rising edge registers call at pass_f
//  pass_f        in   3  floor on which the hall button is pressed
//  elev_f_o      out  3  current car floor
//  busy_o        out  1  1 whenever FSM is not IDLE
// BEHAVIOUR
//  Reset (async, rst_n=1): state=IDLE, elev_f_o=0, busy_o=0, call bitmap=0,
//   move/door counters=0, button edge register=0. Outputs stay so while rst_n=1.
//  Call capture: butt_up_down registered each cycle; rising edge (prev 0, now 1)
//   sets pending[pass_f]. Held-high button produces one call only. pass_f
//   >= NUM_FLOORS ignored. Capture works in every state; a call for the floor
//   currently being served is still kept for later service.
//  States: IDLE, MOVE_P (to pickup), DOOR_P, MOVE_D (to destination), DOOR_D.
//  IDLE: if pending!=0, target = nearest pending floor to elev_f_o (tie ->
//   lower floor); clear that bit; next cycle MOVE_P. Else stay, busy_o=0.
//  MOVE_P/MOVE_D: counter counts MOVE_CYCLES; on terminal count elev_f_o
//   steps +/-1 toward target and counter restarts. When elev_f_o==target
//   (including on entry) go to DOOR_P / DOOR_D respectively.
//  DOOR_P: held DOOR_CYCLES cycles; in the last cycle butt_el sampled as
//   target, then MOVE_D. butt_el >= NUM_FLOORS or == elev_f_o -> MOVE_D
//   immediately satisfied, i.e. next state DOOR_D.
//  DOOR_D: held DOOR_CYCLES cycles, then IDLE.
//  Latency: call while IDLE at floor F: busy_o rises 1 cycle after the edge is
//   sampled; travel = |F-elev|*MOVE_CYCLES cycles; elev_f_o never skips floors.
//  elev_f_o stays within 0..NUM_FLOORS-1; no wrap-around.
//  Simultaneous new call and IDLE selection: new bit joins next selection.
//  Reset mid-operation: everything returns to reset values instantly; pending
//   calls lost.
//  busy_o is registered: busy_o = (next state != IDLE) after each edge.
// TESTING
//  1 Reset: rst_n=1 30ns -> elev_f_o=0, busy_o=0; hold 3 cycles, no change.
//  2 Call pass_f=2 (edge), butt_el=5 -> busy_o=1, elev_f_o 0->1->2 every 4
//    cycles, 3 door cycles, then 2->3->4->5, 3 door cycles, busy_o=0, floor 5.
//  3 butt_up_down held high 50 cycles, pass_f=3 -> exactly one trip to 3;
//    afterwards IDLE at dest, no repeat service.
//  4 Call at current floor 0, butt_el=0 -> no movement, DOOR_P then DOOR_D
//    (6 cycles busy), back to IDLE, elev_f_o=0.
//  5 Car at 5 idle, calls at 7 and 3 in same-length gap -> tie: serves 3
//    first, then 7; calls arriving during a trip retained and served.
//  6 Assert rst_n during MOVE_D at floor 4 -> elev_f_o=0, busy_o=0
//    immediately, pending cleared; pass_f=7 / butt_el=8-range checks ignored.

Source files
------------

// File: rtl/lift_controller.sv
// Single-car lift controller: latches hall calls, serves the nearest one, picks the
// passenger up, carries them to the in-car destination, then idles until the next call.
module lift_controller #(
  parameter int NUM_FLOORS  = 8,
  parameter int MOVE_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] butt_el,
  input  logic       butt_up_down,
  input  logic [2:0] pass_f,
  output logic [2:0] elev_f_o,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CW-1:0] MOVE_LAST = CW'(MOVE_CYCLES - 1);
  localparam logic [CW-1:0] DOOR_LAST = CW'(DOOR_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_MOVE_P = 3'd1,
    S_DOOR_P = 3'd2,
    S_MOVE_D = 3'd3,
    S_DOOR_D = 3'd4
  } state_t;

  state_t                r_state;
  logic [2:0]            r_target;
  logic [NUM_FLOORS-1:0] r_pend;
  logic [CW-1:0]         r_cnt;
  logic                  r_btn;

  logic [NUM_FLOORS-1:0] w_set;
  logic [NUM_FLOORS-1:0] w_clr;
  logic                  w_found;
  logic [2:0]            w_pick;
  logic [2:0]            w_next;
  logic [3:0]            w_best;
  logic [3:0]            w_dist;
  logic                  w_el_ok;

  // Nearest pending floor; scanning upward with a strict compare resolves ties low.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_best  = 4'hF;
    w_dist  = '0;
    for (int f = 0; f < NUM_FLOORS; f++) begin
      w_dist = (4'(f) >= {1'b0, elev_f_o}) ? 4'(f) - {1'b0, elev_f_o}
                                           : {1'b0, elev_f_o} - 4'(f);
      if (r_pend[f] && (w_dist < w_best)) begin
        w_best  = w_dist;
        w_pick  = 3'(f);
        w_found = 1'b1;
      end
    end
  end

  assign w_set   = (butt_up_down && !r_btn && (int'(pass_f) < NUM_FLOORS))
                   ? (NUM_FLOORS'(1) << pass_f) : '0;
  assign w_clr   = ((r_state == S_IDLE) && w_found) ? (NUM_FLOORS'(1) << w_pick) : '0;
  assign w_next  = (r_target > elev_f_o) ? elev_f_o + 3'd1 : elev_f_o - 3'd1;
  assign w_el_ok = (int'(butt_el) < NUM_FLOORS) && (butt_el != elev_f_o);
  assign dbg_state_o = r_state;

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state  <= S_IDLE;
      r_target <= '0;
      r_pend   <= '0;
      r_cnt    <= '0;
      r_btn    <= 1'b0;
      elev_f_o <= '0;
      busy_o   <= 1'b0;
    end else begin
      r_btn  <= butt_up_down;
      // A new call wins over the selection clear, so a repeat call for the served floor survives.
      r_pend <= (r_pend & ~w_clr) | w_set;
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          if (w_found) begin
            r_target <= w_pick;
            busy_o   <= 1'b1;
            r_state  <= (w_pick == elev_f_o) ? S_DOOR_P : S_MOVE_P;
          end else begin
            busy_o <= 1'b0;
          end
        end
        S_MOVE_P, S_MOVE_D: begin
          if (r_cnt == MOVE_LAST) begin
            r_cnt    <= '0;
            elev_f_o <= w_next;
            if (w_next == r_target) begin
              r_state <= (r_state == S_MOVE_P) ? S_DOOR_P : S_DOOR_D;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DOOR_P: begin
          if (r_cnt == DOOR_LAST) begin
            r_cnt    <= '0;
            r_target <= butt_el;
            r_state  <= w_el_ok ? S_MOVE_D : S_DOOR_D;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        S_DOOR_D: begin
          if (r_cnt == DOOR_LAST) begin
            r_cnt   <= '0;
            r_state <= S_IDLE;
            busy_o  <= 1'b0;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state <= S_IDLE;
          r_cnt   <= '0;
          busy_o  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lift_controller.sv
// Bench for lift_controller: a trip-plan model predicts floor/busy every cycle,
// and directed scenarios add hand-computed expectations at key points.
module tb_lift_controller;

  localparam int N  = 8;
  localparam int MC = 4;
  localparam int DC = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [2:0] butt_el = 3'd0;
  logic       butt_up_down = 1'b0;
  logic [2:0] pass_f = 3'd0;
  logic [2:0] elev_f_o;
  logic       busy_o;
  logic [2:0] dbg_state_o;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  lift_controller #(.NUM_FLOORS(N), .MOVE_CYCLES(MC), .DOOR_CYCLES(DC)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .butt_el      (butt_el),
    .butt_up_down (butt_up_down),
    .pass_f       (pass_f),
    .elev_f_o     (elev_f_o),
    .busy_o       (busy_o),
    .dbg_state_o  (dbg_state_o)
  );

  // ---------------- model: a queue of post-edge (floor, busy) values per trip ----------------
  typedef struct {
    logic [2:0] fl;
    bit         busy;
    bit         sample;
  } step_t;

  step_t      plan[$];
  logic [2:0] m_floor = 3'd0;
  bit         m_busy = 1'b0;
  bit         m_pend[N];
  bit         m_prev = 1'b0;
  int         m_picks[$];

  task automatic push_leg(input int from, input int to, input bit pickup);
    int    cur;
    step_t s;
    cur = from;
    while (cur != to) begin
      for (int i = 0; i < MC - 1; i++) begin
        s.fl = 3'(cur); s.busy = 1'b1; s.sample = 1'b0; plan.push_back(s);
      end
      cur = (to > cur) ? cur + 1 : cur - 1;
      s.fl = 3'(cur); s.busy = 1'b1; s.sample = 1'b0; plan.push_back(s);
    end
    for (int i = 0; i < DC - 1; i++) begin
      s.fl = 3'(to); s.busy = 1'b1; s.sample = 1'b0; plan.push_back(s);
    end
    s.fl = 3'(to); s.busy = pickup; s.sample = pickup; plan.push_back(s);
  endtask

  function automatic int nearest();
    int best;
    int bd;
    int d;
    best = -1;
    bd   = 99;
    for (int f = 0; f < N; f++) begin
      d = (f > int'(m_floor)) ? f - int'(m_floor) : int'(m_floor) - f;
      if (m_pend[f] && d < bd) begin
        bd   = d;
        best = f;
      end
    end
    return best;
  endfunction

  function automatic bit model_pending();
    bit any;
    any = 1'b0;
    for (int f = 0; f < N; f++) any = any | m_pend[f];
    return any;
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      plan.delete();
      m_floor = 3'd0;
      m_busy  = 1'b0;
      for (int f = 0; f < N; f++) m_pend[f] = 1'b0;
      m_prev  = 1'b0;
    end else begin
      if (plan.size() == 0) begin
        int p;
        p = nearest();
        if (p >= 0) begin
          m_pend[p] = 1'b0;
          m_busy    = 1'b1;
          m_picks.push_back(p);
          push_leg(int'(m_floor), p, 1'b1);
        end else begin
          m_busy = 1'b0;
        end
      end else begin
        step_t e;
        int    d;
        e       = plan.pop_front();
        m_floor = e.fl;
        m_busy  = e.busy;
        if (e.sample) begin
          d = int'(butt_el);
          if (d >= N) d = int'(m_floor);
          push_leg(int'(m_floor), d, 1'b0);
        end
      end
      if (butt_up_down && !m_prev && int'(pass_f) < N) m_pend[pass_f] = 1'b1;
      m_prev = butt_up_down;
    end
  end

  // ---------------- per-cycle compare against the model ----------------
  always @(negedge clk) begin
    n_checks++;
    if (elev_f_o !== m_floor || busy_o !== m_busy) begin
      n_errors++;
      $display("FAIL cycle_cmp t=%0t floor=%0d busy=%0b expected floor=%0d busy=%0b",
               $time, elev_f_o, busy_o, m_floor, m_busy);
    end
  end

  // ---------------- driver / check helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s got=%0d expected=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic press(input int floor);
    @(negedge clk);
    pass_f       = 3'(floor);
    butt_up_down = 1'b1;
    @(negedge clk);
    butt_up_down = 1'b0;
  endtask

  task automatic wait_idle(input string name, input int budget);
    int n;
    n = 0;
    while ((busy_o || m_busy || plan.size() != 0 || model_pending()) && n < budget) begin
      @(negedge clk);
      n++;
    end
    n_checks++;
    if (n >= budget) begin
      n_errors++;
      $display("FAIL %s timeout got=%0d cycles expected<%0d", name, n, budget);
    end
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt;
    int rises;
    int base;
    int n;
    bit prev_b;

    // Reset held 30 ns, then three quiet cycles.
    @(negedge clk);
    chk("rst_floor_a", int'(elev_f_o), 0);
    chk("rst_busy_a", int'(busy_o), 0);
    @(negedge clk);
    chk("rst_floor_b", int'(elev_f_o), 0);
    chk("rst_busy_b", int'(busy_o), 0);
    @(negedge clk);
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("idle_floor", int'(elev_f_o), 0);
    chk("idle_busy", int'(busy_o), 0);

    // Call at the current floor with destination 0: six busy cycles, no movement.
    butt_el = 3'd0;
    press(0);
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy_o) cnt++;
    end
    chk("same_floor_busy_cycles", cnt, 6);
    chk("same_floor_floor", int'(elev_f_o), 0);

    // Pickup at 2, deliver to 5: four cycles per floor, three door cycles per stop.
    butt_el = 3'd5;
    press(2);
    chk("t2_busy_before", int'(busy_o), 0);
    @(negedge clk);
    chk("t2_busy_start", int'(busy_o), 1);
    chk("t2_floor_start", int'(elev_f_o), 0);
    repeat (4) @(negedge clk);
    chk("t2_floor_1", int'(elev_f_o), 1);
    repeat (4) @(negedge clk);
    chk("t2_floor_2", int'(elev_f_o), 2);
    chk("t2_busy_pickup", int'(busy_o), 1);
    repeat (17) @(negedge clk);
    chk("t2_floor_5", int'(elev_f_o), 5);
    chk("t2_busy_last_door", int'(busy_o), 1);
    @(negedge clk);
    chk("t2_busy_end", int'(busy_o), 0);
    chk("t2_floor_end", int'(elev_f_o), 5);

    // At 5: serve 5 itself, meanwhile calls at 7 and 3 (tie -> 3), then 6 during the trip.
    base = m_picks.size();
    butt_el = 3'd5;
    press(5);
    press(7);
    press(3);
    repeat (5) @(negedge clk);
    press(6);
    wait_idle("t5_idle", 300);
    chk("t5_pick_count", m_picks.size() - base, 4);
    if (m_picks.size() - base == 4) begin
      chk("t5_pick0", m_picks[base], 5);
      chk("t5_pick1", m_picks[base + 1], 3);
      chk("t5_pick2", m_picks[base + 2], 6);
      chk("t5_pick3", m_picks[base + 3], 7);
    end
    chk("t5_floor_end", int'(elev_f_o), 5);

    // Button held high for 50 cycles: exactly one trip to 3.
    base = m_picks.size();
    butt_el = 3'd3;
    @(negedge clk);
    pass_f = 3'd3;
    butt_up_down = 1'b1;
    rises = 0;
    prev_b = busy_o;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (busy_o && !prev_b) rises++;
      prev_b = busy_o;
    end
    butt_up_down = 1'b0;
    wait_idle("t3_idle", 100);
    repeat (10) @(negedge clk);
    chk("t3_busy_rises", rises, 1);
    chk("t3_pick_count", m_picks.size() - base, 1);
    chk("t3_floor", int'(elev_f_o), 3);
    chk("t3_busy", int'(busy_o), 0);

    // Reset during delivery at floor 4 with another call pending.
    butt_el = 3'd7;
    press(3);
    press(6);
    n = 0;
    while (elev_f_o != 3'd4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t6_reach_4_in_budget", int'(n < 100), 1);
    #2 rst_n = 1'b1;
    #1;
    chk("t6_rst_floor", int'(elev_f_o), 0);
    chk("t6_rst_busy", int'(busy_o), 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    repeat (20) @(negedge clk);
    chk("t6_pending_lost_busy", int'(busy_o), 0);
    chk("t6_pending_lost_floor", int'(elev_f_o), 0);

    // Normal service resumes after the reset.
    butt_el = 3'd0;
    press(1);
    wait_idle("t7_idle", 100);
    chk("t7_floor", int'(elev_f_o), 0);
    chk("t7_busy", int'(busy_o), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    n_errors++;
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $fatal(1, "watchdog");
  end

endmodule
